// File: rtl/aes_block_loader_if.sv
// Word-stream handshake into the AES block loader.
// Master drives key/text words; slave returns s_ready.
interface aes_block_loader_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_sel;
    logic        s_inv;

    modport master (
        output s_valid, s_data, s_sel, s_inv,
        input  s_ready
    );

    modport slave (
        input  s_valid, s_data, s_sel, s_inv,
        output s_ready
    );
endinterface

// File: rtl/aes_block_loader.sv
// Builds 128-bit key and text blocks from a 32-bit word stream for the AES core.
// Optional BUSY watchdog enabled by `define AES_BLOCK_LOADER_TIMEOUT_EN.
module aes_block_loader #(
    parameter bit MSW_FIRST      = 1'b1,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_block_loader_if.slave    word,
    input  logic                 key_clr,
    output logic [127:0]         plaintext,
    output logic [127:0]         master_key,
    output logic                 inv_en,
    output logic                 core_start,
    input  logic                 core_done,
    output logic                 busy,
    output logic                 key_valid,
    output logic                 err
);

    typedef enum logic [1:0] {
        FILL,
        LAUNCH,
        BUSY
    } state_t;

    state_t     state;
    logic [1:0] key_cnt;
    logic [1:0] txt_cnt;
    logic       text_full;
    logic       key_acc;
    logic       txt_acc;
    logic       wd_hit;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef AES_BLOCK_LOADER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;

    assign wd_hit = (wd_cnt == WD_LAST);
`else
    assign wd_hit = 1'b0;
    assign err    = 1'b0;
`endif

    // Key words may still enter while a full text block waits for its key.
    assign word.s_ready = rst_n && (state == FILL)
                          && !(!word.s_sel && text_full);

    assign key_acc = word.s_valid && word.s_ready && word.s_sel;
    assign txt_acc = word.s_valid && word.s_ready && !word.s_sel;

    function automatic logic [127:0] put(
        input logic [127:0] blk,
        input logic [1:0]   idx,
        input logic [31:0]  w
    );
        logic [1:0] slot;
        slot = MSW_FIRST ? (2'd3 - idx) : idx;
        put = blk;
        put[{slot, 5'd0} +: 32] = w;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            key_cnt    <= 2'd0;
            txt_cnt    <= 2'd0;
            text_full  <= 1'b0;
            key_valid  <= 1'b0;
            inv_en     <= 1'b0;
            core_start <= 1'b0;
            busy       <= 1'b0;
            plaintext  <= '0;
            master_key <= '0;
`ifdef AES_BLOCK_LOADER_TIMEOUT_EN
            wd_cnt     <= '0;
            err        <= 1'b0;
`endif
        end else begin
            core_start <= 1'b0;
            unique case (state)
                FILL: begin
                    // A clear in the same cycle as a key word drops the word.
                    if (key_clr) begin
                        key_valid <= 1'b0;
                        key_cnt   <= 2'd0;
                    end else if (key_acc) begin
                        master_key <= put(master_key, key_cnt, word.s_data);
                        key_cnt    <= key_cnt + 2'd1;
                        if (key_cnt == 2'd3)
                            key_valid <= 1'b1;
                    end
                    if (txt_acc) begin
                        plaintext <= put(plaintext, txt_cnt, word.s_data);
                        txt_cnt   <= txt_cnt + 2'd1;
                        if (txt_cnt == 2'd3) begin
                            text_full <= 1'b1;
                            inv_en    <= word.s_inv;
                        end
                    end
                    if (text_full && key_valid) begin
                        state      <= LAUNCH;
                        core_start <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                LAUNCH: begin
                    state <= BUSY;
`ifdef AES_BLOCK_LOADER_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end
                BUSY: begin
                    if (core_done || wd_hit) begin
                        state     <= FILL;
                        busy      <= 1'b0;
                        text_full <= 1'b0;
`ifdef AES_BLOCK_LOADER_TIMEOUT_EN
                        if (!core_done)
                            err <= 1'b1;
`endif
                    end
`ifdef AES_BLOCK_LOADER_TIMEOUT_EN
                    else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule
